// File: rtl/apb_slv_pkg.sv
// apb_slv_pkg: shared types and helpers for the APB register-file completer.
// Optional feature macro used by the importing modules: APB_SLV_WAIT_EN.
package apb_slv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      READY = 2'd2
   } apb_state_e;

   localparam int WAIT_CNT_W = 4;

   // Register index width; a 2-entry bank still needs one index bit.
   function automatic int apb_slv_idx_w(input int reg_num);
      return (reg_num <= 2) ? 1 : $clog2(reg_num);
   endfunction

   // Expand 4 byte strobes into a 32-bit lane mask.
   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] mask;
      mask = '0;
      for (int i = 0; i < 4; i++) begin
         mask[8*i +: 8] = {8{strb[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/apb_slv_regbank.sv
// apb_slv_regbank: REG_NUM x 32 storage with a byte-strobed write port,
// a combinational read mux and a flat export of all registers.
module apb_slv_regbank
   import apb_slv_pkg::*;
#(
   parameter int REG_NUM = 16,
   parameter int IDX_W   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [IDX_W-1:0]         idx,
   input  logic [31:0]              wdata,
   input  logic [3:0]               strb,
   input  logic [IDX_W-1:0]         rd_idx,
   output logic [31:0]              rdata,
   output logic [REG_NUM-1:0][31:0] regs_o
);

   logic [31:0] mask;
   logic [31:0] reg_q [REG_NUM];

   assign mask  = strb_mask(strb);
   assign rdata = reg_q[rd_idx];

   for (genvar i = 0; i < REG_NUM; i++) begin : g_reg
      logic        en;
      logic [31:0] d;
      assign en = we && (idx == IDX_W'(i));
      // Only strobed lanes take new data; the rest keep their value.
      assign d  = (reg_q[i] & ~mask) | (wdata & mask);
      dffa_rstn #(.W(32)) u_ff (
         .clk (clk),
         .rst (rst),
         .en  (en),
         .d   (d),
         .q   (reg_q[i])
      );
   end

   // Flatten the storage for downstream consumers.
   always_comb begin
      regs_o = '0;
      for (int i = 0; i < REG_NUM; i++) begin
         regs_o[i] = reg_q[i];
      end
   end

endmodule

// File: rtl/dffa_rstn.sv
// dffa_rstn: enabled register with asynchronous active-high clear.
module dffa_rstn #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Load on enable, clear immediately on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/apb_slv_regfile.sv
// apb_slv_regfile: APB3/APB4 completer fronting a bank of 32-bit registers.
// Optional macro APB_SLV_WAIT_EN: when defined, WAIT_CYC wait states are
// inserted through a WAIT state and down-counter; otherwise every transfer
// is zero-wait.
//
// state | meaning
// IDLE  | no transfer; setup phase captures the command
// WAIT  | wait states being counted down (APB_SLV_WAIT_EN only)
// READY | pready_o high; completes on psel_i & penable_i
module apb_slv_regfile
   import apb_slv_pkg::*;
#(
   parameter int APB_AW   = 11,
   parameter int APB_DW   = 32,
   parameter int REG_NUM  = 16,
   parameter int WAIT_CYC = 2
) (
   input  logic                     apb_clk,
   input  logic                     rst_n,
   input  logic                     psel_i,
   input  logic                     penable_i,
   input  logic                     pwrite_i,
   input  logic [APB_AW-1:0]        paddr_i,
   input  logic [31:0]              pwdata_i,
   input  logic [3:0]               pstrb_i,
   input  logic [2:0]               pprot_i,
   output logic [31:0]              prdata_o,
   output logic                     pready_o,
   output logic                     pslverr_o,
   output logic [REG_NUM-1:0][31:0] regs_o
);

   localparam int IDX_W = apb_slv_idx_w(REG_NUM);

   apb_state_e       state_q, state_d;
   logic             wr_q, wr_d;
   logic             err_q, err_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       strb_q, strb_d;
   logic [31:0]      prdata_q, prdata_d;
   logic             pready_q, pready_d;
   logic             pslverr_q, pslverr_d;
`ifdef APB_SLV_WAIT_EN
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
`endif

   logic [IDX_W-1:0] bus_idx;
   logic             bus_err;
   logic [IDX_W-1:0] rd_idx;
   logic [31:0]      rdata;
   logic             we;
   logic             unused_ok;

   // pprot_i is observed but carries no meaning for this block.
   assign unused_ok = ^{pprot_i, 32'(APB_DW), 32'(WAIT_CYC)};

   assign bus_idx = paddr_i[2 +: IDX_W];
   assign bus_err = (paddr_i[1:0] != 2'b00) ||
                    (paddr_i[APB_AW-1:2+IDX_W] != '0);
   // Entering READY straight from IDLE must read with the live bus index.
   assign rd_idx  = (state_q == IDLE) ? bus_idx : idx_q;

   assign prdata_o  = prdata_q;
   assign pready_o  = pready_q;
   assign pslverr_o = pslverr_q;

   // Next-state, command capture and registered-output computation.
   always_comb begin
      state_d   = state_q;
      wr_d      = wr_q;
      err_d     = err_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      prdata_d  = prdata_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      we        = 1'b0;
`ifdef APB_SLV_WAIT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (psel_i && !penable_i) begin
               wr_d    = pwrite_i;
               err_d   = bus_err;
               idx_d   = bus_idx;
               wdata_d = pwdata_i;
               strb_d  = pstrb_i;
`ifdef APB_SLV_WAIT_EN
               cnt_d   = WAIT_CNT_W'(WAIT_CYC);
               if (WAIT_CYC != 0) begin
                  state_d = WAIT;
               end else begin
                  state_d   = READY;
                  pready_d  = 1'b1;
                  pslverr_d = bus_err;
                  if (!pwrite_i) prdata_d = bus_err ? 32'h0 : rdata;
               end
`else
               state_d   = READY;
               pready_d  = 1'b1;
               pslverr_d = bus_err;
               if (!pwrite_i) prdata_d = bus_err ? 32'h0 : rdata;
`endif
            end
         end
`ifdef APB_SLV_WAIT_EN
         WAIT: begin
            if (!psel_i) begin
               state_d = IDLE;
            end else if (cnt_q == WAIT_CNT_W'(1)) begin
               state_d   = READY;
               pready_d  = 1'b1;
               pslverr_d = err_q;
               if (!wr_q) prdata_d = err_q ? 32'h0 : rdata;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`endif
         READY: begin
            if (!psel_i || penable_i) begin
               we        = psel_i && wr_q && !err_q;
               state_d   = IDLE;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
            end
         end
         default: begin
            state_d   = IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
         end
      endcase
   end

   // FSM, captured command and registered outputs.
   always_ff @(posedge apb_clk or posedge rst_n) begin
      if (rst_n) begin
         state_q   <= IDLE;
         wr_q      <= 1'b0;
         err_q     <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
`ifdef APB_SLV_WAIT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_d;
         err_q     <= err_d;
         idx_q     <= idx_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
`ifdef APB_SLV_WAIT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   apb_slv_regbank #(
      .REG_NUM (REG_NUM),
      .IDX_W   (IDX_W)
   ) u_regbank (
      .clk    (apb_clk),
      .rst    (rst_n),
      .we     (we),
      .idx    (idx_q),
      .wdata  (wdata_q),
      .strb   (strb_q),
      .rd_idx (rd_idx),
      .rdata  (rdata),
      .regs_o (regs_o)
   );

endmodule

// File: doc/apb_slv_regfile.md
Name: apb_slv_regfile

Overview:
- APB3/APB4 completer (responder) holding a bank of REG_NUM 32-bit control/status registers; one instance sits on each psel_o[n] line driven by the AHB-to-APB bridge core.
- Supports optional programmable wait states, byte strobes and PSLVERR for misaligned or out-of-range accesses.
- Register contents are exported to downstream logic as a flat register array.

Parameters:
APB_AW    11   APB address width, byte address
APB_DW    32   APB data width; only 32 is supported
REG_NUM   16   number of registers, power of 2, 2..256
WAIT_CYC  2    wait states inserted per transfer, 0..15; used only with APB_SLV_WAIT_EN

Ports:
apb_clk    input   1                  APB clock; single clock domain
rst_n      input   1                  reset, asynchronous, active-high
psel_i     input   1                  slave select
penable_i  input   1                  access phase indicator
pwrite_i   input   1                  1 = write, 0 = read
paddr_i    input   APB_AW             byte address
pwdata_i   input   32                 write data
pstrb_i    input   4                  byte write strobes
pprot_i    input   3                  protection attributes; sampled, not acted on
prdata_o   output  32                 read data
pready_o   output  1                  transfer complete
pslverr_o  output  1                  transfer error
regs_o     output  REG_NUM x 32       current register contents

Behaviour:
- Clock and reset: one clock, apb_clk. Reset rst_n is asynchronous and active-high.
- Reset values: all registers in regs_o = 0, prdata_o = 0, pready_o = 0, pslverr_o = 0, state = IDLE.
- Address decode:
  - idx = paddr_i[2 +: log2(REG_NUM)].
  - err = (paddr_i[1:0] != 0) OR (paddr_i[APB_AW-1 : 2+log2(REG_NUM)] != 0).
  - Decode is evaluated at setup and captured together with pwrite_i, pwdata_i and pstrb_i.
- FSM states: IDLE, WAIT, READY. All outputs are registered.
  - IDLE: on psel_i=1 and penable_i=0, capture the command and load cnt = WAIT_CYC. Go to READY if WAIT_CYC = 0, otherwise go to WAIT.
  - WAIT: pready_o = 0; cnt decrements each cycle. When cnt = 1, go to READY.
  - READY: pready_o = 1; pslverr_o = err; for reads, prdata_o = reg[idx] (0 on error), loaded on entry to READY. On psel_i=1 and penable_i=1 the transfer completes on that edge:
    - a write with no error updates each byte lane of reg[idx] whose pstrb_i bit is set;
    - the FSM returns to IDLE and clears pready_o and pslverr_o.
- Latency: access phase = WAIT_CYC+1 cycles (pready_o high in the last cycle). The next setup is accepted in the cycle after completion; back-to-back transfers take WAIT_CYC+2 cycles each.
- Write with pstrb_i = 0: completes normally, no register change, no error.
- Reads ignore pstrb_i. Erroring writes change nothing.
- prdata_o holds its last value outside READY and is not cleared by writes.
- Abort: psel_i=0 while in WAIT or READY returns the FSM to IDLE, drops pready_o, and commits nothing.
- Protocol violation: psel_i=1 and penable_i=1 in IDLE (no setup phase) is ignored; FSM stays in IDLE.
- Reset mid-transfer: immediately forces reset values; any pending write is lost.
- regs_o reflects a write on the cycle after the completion edge.

Optional Feature:
- Macro: APB_SLV_WAIT_EN.
- Defined: WAIT state and a 4-bit counter are present and WAIT_CYC wait states are inserted.
- Undefined: WAIT state and counter are not synthesized; WAIT_CYC is ignored; IDLE always goes to READY (zero-wait, 2-cycle transfers).

Decomposition:
- Package apb_slv_pkg:
  - state enum typedef (IDLE/WAIT/READY);
  - APB_SLV_IDX_W function/constant derived from REG_NUM;
  - WAIT_CNT_W = 4;
  - byte-lane mask helper function.
- Sub-module apb_slv_regbank: REG_NUM x 32 storage with byte-strobed write port (we, idx, wdata, strb), combinational read mux and flat regs_o. Registers are built from dffa_rstn instances.
- The FSM, decode and counter stay in apb_slv_regfile.

Test Plan:
1. Zero-wait write (macro off): paddr=0x008, pwdata=0xDEADBEEF, pstrb=4'hF → pready_o high on the 2nd cycle; regs_o[2] = 0xDEADBEEF; pslverr_o = 0.
2. WAIT_CYC=2 read (macro on) after test 1: read paddr=0x008 → pready_o low for 2 access cycles, then high with prdata_o = 0xDEADBEEF.
3. Byte strobe: reg[2] = 0xDEADBEEF, write 0x11223344 with pstrb=4'b0101 → reg[2] = 0xDE22BE44.
4. Errors: read paddr=0x006, then write paddr=0x040 (REG_NUM=16) → pslverr_o = 1 with pready_o for each; prdata_o = 0; no register changes.
5. Abort and reset: deassert psel_i during WAIT → no write, FSM back in IDLE. Assert rst_n=1 mid-READY → all registers, prdata_o and pready_o = 0 asynchronously.
